noc_vc_output_port: RTL and testbench

Parametrised next-generation router output port. Arbitrates flits from N_IN input modules across N_VC virtual channels onto one output link.
- Per-VC round-robin arbitration with wormhole locking from head to tail.
- Fixed priority between VCs: higher index wins.
- Credit-based flow control per VC.
- Registered output stage.

---
 rtl/noc_vc_output_port.sv | 153 +++++++++++++++
 tb/tb_noc_vc_output_port.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_vc_output_port.sv
// Router output port: per-VC round-robin arbitration with wormhole locking, fixed VC
// priority (highest index wins), per-VC credit flow control and a registered output stage.
module noc_vc_output_port #(
    parameter int N_IN    = 4,
    parameter int N_VC    = 3,
    parameter int FLIT_W  = 34,
    parameter int CREDITS = 4,
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int VW = (N_VC > 1) ? $clog2(N_VC) : 1
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [N_IN-1:0]        fin_valid_i,
    input  logic [N_IN*FLIT_W-1:0] fin_flit_i,
    input  logic [N_IN*VW-1:0]     fin_vc_i,
    output logic [N_IN-1:0]        fin_ready_o,
    output logic                   fout_valid_o,
    output logic [FLIT_W-1:0]      fout_flit_o,
    output logic [VW-1:0]          fout_vc_o,
    input  logic [N_VC-1:0]        fout_credit_i
);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [1:0] T_HEAD   = 2'b00;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic [FLIT_W-1:0] in_flit [N_IN];
    logic [VW-1:0]     in_vc   [N_IN];
    logic [1:0]        in_type [N_IN];

    for (genvar k = 0; k < N_IN; k++) begin : g_unpack
        assign in_flit[k] = fin_flit_i[k*FLIT_W +: FLIT_W];
        assign in_vc[k]   = fin_vc_i[k*VW +: VW];
        assign in_type[k] = in_flit[k][FLIT_W-1 -: 2];
    end

    logic [N_VC-1:0] lock;
    logic [IW-1:0]   owner  [N_VC];
    logic [IW-1:0]   rr_ptr [N_VC];
    logic [CW-1:0]   credit [N_VC];

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_IN) s = s - N_IN;
        return IW'(s);
    endfunction

    // Inputs offering a packet-opening flit (head or single) on each VC.
    logic [N_IN-1:0] head_req [N_VC];
    always_comb begin
        for (int v = 0; v < N_VC; v++) begin
            for (int k = 0; k < N_IN; k++) begin
                head_req[v][k] = fin_valid_i[k] && (in_vc[k] == VW'(v)) &&
                                 (in_type[k] == T_HEAD || in_type[k] == T_SINGLE);
            end
        end
    end

    logic [N_VC-1:0] vc_elig;
    logic [IW-1:0]   vc_pick [N_VC];
    always_comb begin
        for (int v = 0; v < N_VC; v++) begin
            vc_elig[v] = 1'b0;
            vc_pick[v] = '0;
            if (credit[v] != '0) begin
                if (lock[v]) begin
                    // A locked VC only follows its owner; other inputs' flits wait.
                    vc_elig[v] = fin_valid_i[owner[v]] && (in_vc[owner[v]] == VW'(v));
                    vc_pick[v] = owner[v];
                end else begin
                    for (int i = 0; i < N_IN; i++) begin
                        if (!vc_elig[v] && head_req[v][wrap_add(rr_ptr[v], i)]) begin
                            vc_elig[v] = 1'b1;
                            vc_pick[v] = wrap_add(rr_ptr[v], i);
                        end
                    end
                end
            end
        end
    end

    logic            win_any;
    logic [VW-1:0]   win_vc;
    logic [IW-1:0]   win_in;
    logic            xfer;
    logic [N_VC-1:0] send_vc;
    logic [1:0]      win_type;

    always_comb begin
        win_any = 1'b0;
        win_vc  = '0;
        win_in  = '0;
        for (int v = 0; v < N_VC; v++) begin
            if (vc_elig[v]) begin
                win_any = 1'b1;
                win_vc  = VW'(v);
                win_in  = vc_pick[v];
            end
        end
        xfer        = win_any && !arst;
        fin_ready_o = '0;
        send_vc     = '0;
        if (xfer) begin
            fin_ready_o[win_in] = 1'b1;
            send_vc[win_vc]     = 1'b1;
        end
        win_type = in_type[win_in];
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int v = 0; v < N_VC; v++) begin
                lock[v]   <= 1'b0;
                owner[v]  <= '0;
                rr_ptr[v] <= '0;
                credit[v] <= CW'(CREDITS);
            end
        end else begin
            for (int v = 0; v < N_VC; v++) begin
                if (send_vc[v]) begin
                    if (win_type == T_HEAD) begin
                        lock[v]  <= 1'b1;
                        owner[v] <= win_in;
                    end else if (win_type == T_TAIL || win_type == T_SINGLE) begin
                        lock[v]   <= 1'b0;
                        rr_ptr[v] <= wrap_add(win_in, 1);
                    end
                end
                // A send and a returned credit in the same cycle cancel out.
                if (send_vc[v] && !fout_credit_i[v]) begin
                    credit[v] <= credit[v] - CW'(1);
                end else if (!send_vc[v] && fout_credit_i[v] && credit[v] != CW'(CREDITS)) begin
                    credit[v] <= credit[v] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            fout_valid_o <= 1'b0;
            fout_flit_o  <= '0;
            fout_vc_o    <= '0;
        end else begin
            fout_valid_o <= xfer;
            if (xfer) begin
                fout_flit_o <= in_flit[win_in];
                fout_vc_o   <= win_vc;
            end
        end
    end
endmodule

// File: tb/tb_noc_vc_output_port.sv
// Bench for noc_vc_output_port: reset-state vector table, directed multi-cycle
// sequences and randomized packet traffic against a queue-based reference model.
module tb_noc_vc_output_port;
    localparam int N_IN    = 4;
    localparam int N_VC    = 3;
    localparam int FLIT_W  = 34;
    localparam int CREDITS = 4;
    localparam int VW      = 2;
    localparam int W       = VW + FLIT_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    logic [N_IN-1:0]        valid_bus;
    logic [N_IN*FLIT_W-1:0] flit_bus;
    logic [N_IN*VW-1:0]     vc_bus;
    logic [N_IN-1:0]        fin_ready_o;
    logic                   fout_valid_o;
    logic [FLIT_W-1:0]      fout_flit_o;
    logic [VW-1:0]          fout_vc_o;
    logic [N_VC-1:0]        cred;

    noc_vc_output_port #(.N_IN(N_IN), .N_VC(N_VC), .FLIT_W(FLIT_W), .CREDITS(CREDITS)) dut (
        .clk(clk), .arst(arst),
        .fin_valid_i(valid_bus), .fin_flit_i(flit_bus), .fin_vc_i(vc_bus),
        .fin_ready_o(fin_ready_o),
        .fout_valid_o(fout_valid_o), .fout_flit_o(fout_flit_o), .fout_vc_o(fout_vc_o),
        .fout_credit_i(cred)
    );

    // ---------------- driver state ----------------
    logic              in_v [N_IN];
    logic [FLIT_W-1:0] in_f [N_IN];
    logic [VW-1:0]     in_c [N_IN];
    int                p_len [N_IN];
    int                p_pos [N_IN];
    int                last_grant;

    always_comb begin
        for (int k = 0; k < N_IN; k++) begin
            valid_bus[k]                 = in_v[k];
            flit_bus[k*FLIT_W +: FLIT_W] = in_f[k];
            vc_bus[k*VW +: VW]           = in_c[k];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_flit(input int i);
        logic [1:0] t;
        if (p_len[i] == 1)                t = 2'b11;
        else if (p_pos[i] == 0)           t = 2'b00;
        else if (p_pos[i] == p_len[i] - 1) t = 2'b10;
        else                              t = 2'b01;
        in_f[i] = {t, 32'($urandom)};
        in_v[i] = 1'b1;
    endtask

    task automatic start_pkt(input int i, input int vc, input int len);
        p_len[i] = len;
        p_pos[i] = 0;
        in_c[i]  = VW'(vc);
        load_flit(i);
    endtask

    task automatic advance(input int i);
        p_pos[i]++;
        if (p_pos[i] >= p_len[i]) begin
            in_v[i]  = 1'b0;
            p_len[i] = 0;
        end else begin
            load_flit(i);
        end
    endtask

    task automatic idle_all();
        for (int i = 0; i < N_IN; i++) begin
            in_v[i] = 1'b0; in_f[i] = '0; in_c[i] = '0; p_len[i] = 0; p_pos[i] = 0;
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    int           m_lock  [N_VC];
    int           m_owner [N_VC];
    int           m_rr    [N_VC];
    int           m_cred  [N_VC];
    bit           m_out_valid;
    logic [W-1:0] exp_q [$];

    task automatic model_reset();
        for (int v = 0; v < N_VC; v++) begin
            m_lock[v] = 0; m_owner[v] = 0; m_rr[v] = 0; m_cred[v] = CREDITS;
        end
        m_out_valid = 1'b0;
        exp_q.delete();
    endtask

    // Highest VC with credit that has a legal candidate wins.
    task automatic model_pick(output int g_in, output int g_vc);
        g_in = -1;
        g_vc = -1;
        for (int v = N_VC - 1; v >= 0 && g_in < 0; v--) begin
            if (m_cred[v] > 0) begin
                if (m_lock[v] != 0) begin
                    if (in_v[m_owner[v]] && int'(in_c[m_owner[v]]) == v) begin
                        g_in = m_owner[v];
                        g_vc = v;
                    end
                end else begin
                    for (int k = 0; k < N_IN && g_in < 0; k++) begin
                        int i;
                        int t;
                        i = (m_rr[v] + k) % N_IN;
                        t = int'(in_f[i][FLIT_W-1 -: 2]);
                        if (in_v[i] && int'(in_c[i]) == v && (t == 0 || t == 3)) begin
                            g_in = i;
                            g_vc = v;
                        end
                    end
                end
            end
        end
    endtask

    // One clock: check ready and output against the model, then advance the model.
    task automatic step();
        int g_in;
        int g_vc;
        int t;
        logic [N_IN-1:0] exp_ready;
        logic [W-1:0] item;
        @(negedge clk);
        model_pick(g_in, g_vc);
        exp_ready = '0;
        if (g_in >= 0) exp_ready[g_in] = 1'b1;
        check("ready", 64'(fin_ready_o), 64'(exp_ready));
        check("out_valid", 64'(fout_valid_o), 64'(m_out_valid));
        if (m_out_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL out_flit: got %0h, scoreboard empty", {fout_vc_o, fout_flit_o});
            end else begin
                item = exp_q.pop_front();
                check("out_flit", 64'({fout_vc_o, fout_flit_o}), 64'(item));
            end
        end
        m_out_valid = (g_in >= 0);
        last_grant  = g_in;
        if (g_in >= 0) begin
            exp_q.push_back({VW'(g_vc), in_f[g_in]});
            t = int'(in_f[g_in][FLIT_W-1 -: 2]);
            if (t == 0) begin
                m_lock[g_vc] = 1; m_owner[g_vc] = g_in;
            end else if (t >= 2) begin
                m_lock[g_vc] = 0; m_rr[g_vc] = (g_in + 1) % N_IN;
            end
        end
        for (int v = 0; v < N_VC; v++) begin
            if (g_vc == v && !cred[v]) m_cred[v] = m_cred[v] - 1;
            else if (g_vc != v && cred[v] && m_cred[v] < CREDITS) m_cred[v] = m_cred[v] + 1;
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        arst = 1'b1;
        idle_all();
        cred = '0;
        @(posedge clk); #1;
        check("rst_out_valid", 64'(fout_valid_o), 64'd0);
        check("rst_out_flit", 64'({fout_vc_o, fout_flit_o}), 64'd0);
        @(posedge clk); #1;
        arst = 1'b0;
        model_reset();
    endtask

    task automatic reset_mid_stream();
        arst = 1'b1;
        #2;
        check("rst_mid_ready", 64'(fin_ready_o), 64'd0);
        check("rst_mid_out_valid", 64'(fout_valid_o), 64'd0);
        @(posedge clk); #1;
        check("rst_mid_ready_hold", 64'(fin_ready_o), 64'd0);
        arst = 1'b0;
        model_reset();
        idle_all();
        cred = '0;
        start_pkt(3, 0, 2);
        step();
        check("post_rst_first_grant", 64'(last_grant), 64'(3));
    endtask

    // ---------------- vector table (each applied from the reset state) ----------------
    typedef struct {
        logic [N_IN-1:0]       valid;
        logic [N_IN-1:0][1:0]  vc;
        logic [N_IN-1:0][1:0]  typ;
        logic [N_IN-1:0]       exp_ready;
        logic [1:0]            exp_vc;
    } vec_t;
    vec_t vecs [8];

    int seq [8];
    int cnt;

    initial begin
        arst = 1'b1;
        cred = '0;
        last_grant = -1;
        idle_all();
        model_reset();

        vecs[0] = '{valid: 4'b0000, vc: 8'h00, typ: 8'h00, exp_ready: 4'b0000, exp_vc: 2'd0};
        vecs[1] = '{valid: 4'b1111, vc: 8'h00, typ: 8'hFF, exp_ready: 4'b0001, exp_vc: 2'd0};
        vecs[2] = '{valid: 4'b1010, vc: {2'd2, 2'd0, 2'd1, 2'd0}, typ: 8'h00, exp_ready: 4'b1000, exp_vc: 2'd2};
        vecs[3] = '{valid: 4'b0110, vc: {2'd0, 2'd1, 2'd1, 2'd0}, typ: {2'b00, 2'b00, 2'b01, 2'b00}, exp_ready: 4'b0100, exp_vc: 2'd1};
        vecs[4] = '{valid: 4'b0001, vc: {2'd0, 2'd0, 2'd0, 2'd2}, typ: {2'b00, 2'b00, 2'b00, 2'b10}, exp_ready: 4'b0000, exp_vc: 2'd0};
        vecs[5] = '{valid: 4'b1100, vc: 8'h00, typ: 8'h00, exp_ready: 4'b0100, exp_vc: 2'd0};
        vecs[6] = '{valid: 4'b0011, vc: {2'd0, 2'd0, 2'd0, 2'd1}, typ: {2'b00, 2'b00, 2'b00, 2'b11}, exp_ready: 4'b0001, exp_vc: 2'd1};
        vecs[7] = '{valid: 4'b1001, vc: {2'd1, 2'd0, 2'd0, 2'd2}, typ: {2'b11, 2'b00, 2'b00, 2'b01}, exp_ready: 4'b1000, exp_vc: 2'd1};

        for (int n = 0; n < 8; n++) begin
            int w;
            apply_reset();
            for (int k = 0; k < N_IN; k++) begin
                in_v[k] = vecs[n].valid[k];
                in_c[k] = vecs[n].vc[k];
                in_f[k] = {vecs[n].typ[k], 32'(100 + k)};
            end
            @(negedge clk);
            check($sformatf("vec%0d_ready", n), 64'(fin_ready_o), 64'(vecs[n].exp_ready));
            @(posedge clk); #1;
            check($sformatf("vec%0d_out_valid", n), 64'(fout_valid_o), 64'(|vecs[n].exp_ready));
            if (vecs[n].exp_ready != '0) begin
                w = 0;
                for (int k = 0; k < N_IN; k++) if (vecs[n].exp_ready[k]) w = k;
                check($sformatf("vec%0d_out_vc", n), 64'(fout_vc_o), 64'(vecs[n].exp_vc));
                check($sformatf("vec%0d_out_flit", n), 64'(fout_flit_o),
                      64'({vecs[n].typ[w], 32'(100 + w)}));
            end
        end

        // Round robin over single-flit packets on VC0, all inputs always valid.
        apply_reset();
        cred = 3'b001;
        for (int i = 0; i < N_IN; i++) start_pkt(i, 0, 1);
        seq = '{0, 1, 2, 3, 0, 0, 0, 0};
        for (int c = 0; c < 5; c++) begin
            step();
            check($sformatf("rr_grant%0d", c), 64'(last_grant), 64'(seq[c]));
            if (last_grant >= 0) begin
                advance(last_grant);
                start_pkt(last_grant, 0, 1);
            end
        end
        step();

        // Wormhole lock: input 2 owns VC1 for four flits while input 0 waits.
        apply_reset();
        cred = 3'b010;
        start_pkt(2, 1, 4);
        seq = '{2, 2, 2, 2, 0, -1, 0, 0};
        for (int c = 0; c < 6; c++) begin
            step();
            check($sformatf("worm_grant%0d", c), 64'(last_grant), 64'(seq[c]));
            if (last_grant >= 0) advance(last_grant);
            if (c == 0) start_pkt(0, 1, 1);
        end

        // VC priority and interleave once VC2 runs out of credit.
        apply_reset();
        start_pkt(0, 0, 3);
        start_pkt(1, 2, 6);
        seq = '{1, 1, 1, 1, 0, 0, 0, -1};
        for (int c = 0; c < 8; c++) begin
            step();
            check($sformatf("prio_grant%0d", c), 64'(last_grant), 64'(seq[c]));
            if (last_grant >= 0) advance(last_grant);
        end

        // Credit exhaustion, single return, and same-cycle send plus return.
        apply_reset();
        start_pkt(0, 1, 6);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (last_grant >= 0) begin cnt++; advance(last_grant); end
        end
        check("cred_exhaust_sent", 64'(cnt), 64'd4);
        cred = 3'b010;
        step();
        check("cred_pulse_no_send", 64'(last_grant), -64'sd1);
        cred = '0;
        cnt = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (last_grant >= 0) begin cnt++; advance(last_grant); end
        end
        check("cred_one_more", 64'(cnt), 64'd1);
        cred = 3'b010;
        step();
        step();
        check("cred_same_cycle_send", 64'(last_grant), 64'd0);
        if (last_grant >= 0) advance(last_grant);
        cred = '0;
        start_pkt(1, 1, 1);
        step();
        check("cred_kept_after_same_cycle", 64'(last_grant), 64'd1);
        if (last_grant >= 0) advance(last_grant);
        start_pkt(1, 1, 1);
        step();
        check("cred_empty_again", 64'(last_grant), -64'sd1);
        step();

        // Credit saturation: returns at full count are ignored.
        apply_reset();
        cred = 3'b001;
        step();
        step();
        cred = '0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (!in_v[0]) start_pkt(0, 0, 1);
            step();
            if (last_grant >= 0) begin cnt++; advance(last_grant); end
        end
        check("cred_saturate_sent", 64'(cnt), 64'd4);

        // Randomized packet traffic with a reset in the middle of the stream.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) reset_mid_stream();
            for (int i = 0; i < N_IN; i++) begin
                if (!in_v[i] && $urandom_range(0, 3) == 0)
                    start_pkt(i, int'($urandom_range(0, N_VC - 1)), int'($urandom_range(1, 5)));
            end
            cred = N_VC'($urandom) & N_VC'($urandom);
            step();
            if (last_grant >= 0) advance(last_grant);
        end
        idle_all();
        cred = '0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
